// File: rtl/vram_frame_writer.sv
// Queues host VRAM writes, commits them per frame, and streams the committed writes
// to the h2f_vram port when the PPU signals irq. Optional stats: VRAM_FRAME_WRITER_STATS_EN.
module vram_frame_writer #(
  parameter int FIFO_DEPTH = 64,
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [ADDR_W-1:0]                cmd_addr,
  input  logic [DATA_W-1:0]                cmd_data,
  input  logic [DATA_W/8-1:0]              cmd_byteena,
  input  logic                             frame_commit,
  input  logic                             cpu_vram_wr_irq,
  output logic                             cpu_wr_busy,
  output logic [ADDR_W-1:0]                h2f_vram_wraddr,
  output logic                             h2f_vram_wren,
  output logic [DATA_W-1:0]                h2f_vram_wrdata,
  output logic [DATA_W/8-1:0]              h2f_vram_byteena,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  uncommitted_cnt,
  output logic                             dbg_state
`ifdef VRAM_FRAME_WRITER_STATS_EN
  ,
  output logic [15:0]                      frames_written,
  output logic [15:0]                      late_irqs
`endif
);

  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W = ADDR_W + DATA_W + BE_W;

  typedef enum logic [0:0] {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  state_t              state_q;
  logic [ENT_W-1:0]    mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    occ_q, occ_d, unc_q, unc_d, com_q, com_d, com_eff, rem_q;
  logic                full, push, pop, irq_go, drain_more;
  logic [ENT_W-1:0]    cmd_ent, head, out_q;
  logic                wren_q, busy_q;

  assign full      = (occ_q == CNT_W'(FIFO_DEPTH));
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign cmd_ent   = {cmd_addr, cmd_data, cmd_byteena};
  // An empty FIFO can only be popped when the entry is being pushed this very cycle.
  assign head      = (occ_q == '0) ? cmd_ent : mem_q[rd_ptr_q];

  // Commit is folded in before the irq decision so a same-cycle commit joins the drain.
  always_comb begin
    com_eff = com_q;
    unc_d   = unc_q + CNT_W'(push);
    if (frame_commit) begin
      com_eff = com_q + unc_q + CNT_W'(push);
      unc_d   = '0;
    end
  end

  assign irq_go     = (state_q == IDLE) && cpu_vram_wr_irq && (com_eff != '0);
  assign drain_more = (state_q == DRAIN) && (rem_q != '0);
  assign pop        = irq_go || drain_more;
  assign com_d      = irq_go ? '0 : com_eff;
  assign occ_d      = occ_q + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_ent;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      unc_q    <= '0;
      com_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      occ_q <= occ_d;
      unc_q <= unc_d;
      com_q <= com_d;
    end
  end

  // rem_q counts writes still owed after the one currently on the port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      wren_q  <= 1'b0;
      busy_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (irq_go) begin
            state_q <= DRAIN;
            rem_q   <= com_eff - CNT_W'(1);
            wren_q  <= 1'b1;
            busy_q  <= 1'b1;
            out_q   <= head;
          end else begin
            wren_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        DRAIN: begin
          if (drain_more) begin
            rem_q  <= rem_q - CNT_W'(1);
            wren_q <= 1'b1;
            out_q  <= head;
          end else begin
            state_q <= IDLE;
            wren_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign h2f_vram_wren = wren_q;
  assign cpu_wr_busy   = busy_q;
  assign {h2f_vram_wraddr, h2f_vram_wrdata, h2f_vram_byteena} = out_q;
  assign uncommitted_cnt = unc_q;
  assign dbg_state       = state_q;

`ifdef VRAM_FRAME_WRITER_STATS_EN
  logic [15:0] frames_q, late_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frames_q <= '0;
      late_q   <= '0;
    end else begin
      if ((state_q == DRAIN) && !drain_more && (frames_q != 16'hFFFF))
        frames_q <= frames_q + 16'd1;
      if (cpu_vram_wr_irq && !irq_go && (late_q != 16'hFFFF))
        late_q <= late_q + 16'd1;
    end
  end

  assign frames_written = frames_q;
  assign late_irqs      = late_q;
`endif

endmodule
